// File: rtl/riscv_hpm_unit.sv
// Machine/user counter block: mcycle, minstret and programmable hpm counters with
// event selectors, inhibit/enable masks, registered CSR reads and sticky overflow flags.
module riscv_hpm_unit #(
    parameter int XLEN          = 64,
    parameter int NUM_COUNTERS  = 14,
    parameter int NUM_EVENTS    = 14,
    parameter int COUNTER_WIDTH = 64,
    parameter int RETIRE_WIDTH  = 2
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [1:0]                        priv_i,
    input  logic [NUM_EVENTS-1:0]             event_i,
    input  logic [$clog2(RETIRE_WIDTH+1)-1:0] retire_cnt_i,
    input  logic                              csr_ren_i,
    input  logic                              csr_wen_i,
    input  logic [11:0]                       csr_adr_i,
    input  logic [XLEN-1:0]                   csr_wdata_i,
    output logic [XLEN-1:0]                   csr_rdata_o,
    output logic                              csr_rvalid_o,
    output logic                              csr_illegal_o,
    output logic [NUM_COUNTERS+2:0]           ovf_o
);

    localparam int NC = NUM_COUNTERS + 3;
    localparam int RW = $clog2(RETIRE_WIDTH + 1);
    localparam int EW = $clog2(NUM_EVENTS + 1);
    // Extra headroom so a multi-retire step that crosses the wrap still shows a carry.
    localparam int SW = COUNTER_WIDTH + RW;
    localparam logic [32:0] ALL_ONES  = (33'd1 << NC) - 33'd1;
    localparam logic [31:0] IMPL_MASK = ALL_ONES[31:0] & ~32'd2;

    logic [4:0]      idx;
    logic            is_mcnt, is_ucnt, is_evt, is_cen, is_m;
    logic            hpm_ok, cnt_ok, evt_ok;
    logic            rd_legal, wr_legal, wr_ok;
    logic [31:0]     inh_reg, cen_reg;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] cnt_rd [32];
    logic [XLEN-1:0] evt_rd [32];
    logic [NUM_EVENTS:0] ev_ext;

    assign idx    = csr_adr_i[4:0];
    assign ev_ext = {event_i, 1'b0};

    always_comb begin
        is_mcnt  = (csr_adr_i[11:5] == 7'b1011000);
        is_ucnt  = (csr_adr_i[11:5] == 7'b1100000);
        is_evt   = (csr_adr_i[11:5] == 7'b0011001);
        is_cen   = (csr_adr_i == 12'h306);
        is_m     = (priv_i == 2'b11);
        hpm_ok   = (idx >= 5'd3) && ({27'd0, idx} < 32'(NC));
        cnt_ok   = (idx == 5'd0) || (idx == 5'd2) || hpm_ok;
        evt_ok   = (idx == 5'd0) || hpm_ok;
        rd_legal = is_m ? (((is_mcnt || is_ucnt) && cnt_ok) || (is_evt && evt_ok) || is_cen)
                        : (is_ucnt && cnt_ok && cen_reg[idx]);
        wr_legal = is_m && ((is_mcnt && cnt_ok) || (is_evt && evt_ok) || is_cen);
        wr_ok    = csr_wen_i && wr_legal;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_ctr
            if (gi == 1 || gi >= NC) begin : g_none
                assign cnt_rd[gi] = '0;
                assign evt_rd[gi] = '0;
            end else begin : g_impl
                logic [COUNTER_WIDTH-1:0] cnt_reg;
                logic                     ovf_reg;
                logic [SW-1:0]            inc;
                logic [SW-1:0]            sum;
                logic                     wr_hit;

                if (gi >= 3) begin : g_evt
                    logic [EW-1:0] evt_reg;

                    // Selector is WARL: anything above the last event parks at 0 (never counts).
                    always_ff @(posedge clk) begin
                        if (!reset_n) begin
                            evt_reg <= '0;
                        end else if (wr_ok && is_evt && idx == 5'(gi)) begin
                            evt_reg <= (csr_wdata_i > XLEN'(NUM_EVENTS)) ? '0 : csr_wdata_i[EW-1:0];
                        end
                    end

                    assign inc        = SW'(ev_ext[evt_reg]);
                    assign evt_rd[gi] = XLEN'(evt_reg);
                end else begin : g_fixed
                    assign inc        = (gi == 0) ? SW'(1) : SW'(retire_cnt_i);
                    assign evt_rd[gi] = '0;
                end

                assign wr_hit = wr_ok && is_mcnt && (idx == 5'(gi));
                assign sum    = SW'(cnt_reg) + inc;

                always_ff @(posedge clk) begin
                    if (!reset_n) begin
                        cnt_reg <= '0;
                        ovf_reg <= 1'b0;
                    end else if (wr_hit) begin
                        cnt_reg <= csr_wdata_i[COUNTER_WIDTH-1:0];
                        ovf_reg <= 1'b0;
                    end else if (!inh_reg[gi]) begin
                        cnt_reg <= sum[COUNTER_WIDTH-1:0];
                        if (|sum[SW-1:COUNTER_WIDTH]) begin
                            ovf_reg <= 1'b1;
                        end
                    end
                end

                assign cnt_rd[gi] = XLEN'(cnt_reg);
                assign ovf_o[gi]  = ovf_reg;
            end
        end
    endgenerate

    assign ovf_o[1] = 1'b0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inh_reg <= '0;
            cen_reg <= '0;
        end else begin
            if (wr_ok && is_evt && idx == 5'd0) begin
                inh_reg <= csr_wdata_i[31:0] & IMPL_MASK;
            end
            if (wr_ok && is_cen) begin
                cen_reg <= csr_wdata_i[31:0] & IMPL_MASK;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (is_mcnt || is_ucnt) begin
            rd_val = cnt_rd[idx];
        end else if (is_evt) begin
            rd_val = (idx == 5'd0) ? XLEN'(inh_reg) : evt_rd[idx];
        end else if (is_cen) begin
            rd_val = XLEN'(cen_reg);
        end
    end

    // An illegal write flags csr_illegal_o the next cycle even without a read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            csr_rdata_o   <= '0;
            csr_rvalid_o  <= 1'b0;
            csr_illegal_o <= 1'b0;
        end else begin
            csr_rvalid_o  <= csr_ren_i;
            csr_illegal_o <= (csr_ren_i && !rd_legal) || (csr_wen_i && !wr_legal);
            csr_rdata_o   <= (csr_ren_i && rd_legal) ? rd_val : '0;
        end
    end

endmodule
